mcm_dual_pipe: RTL and testbench



---
 rtl/mcm_dual_pipe.sv | 161 ++++++++++++++++
 tb/tb_mcm_dual_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcm_dual_pipe.sv
// mcm_dual_pipe: dual-constant multiplier sharing one packed wide multiply.
//
// Computes y0 = x*k0 and y1 = x*k1 for a signed sample x and unsigned constants
// k0/k1. The constants are packed as A = (k1 << S) + k0 with S = W+CW. One signed
// multiply x*A then yields both products. A sign fix-up on the upper field undoes
// the borrow that a negative low field introduces.
//
// The product is formed combinationally and captured into stage 0. Stages
// 1..LAT-1 only carry data. Flow control is valid/ready with back-pressure. A
// stage may take new data when it is empty or when its contents move on.
//
// Optional feature: define MCM_DUAL_PIPE_RELOAD_EN to build run-time loadable
// constant registers (k_load/k0_in/k1_in). Without it the inputs are ignored and
// K0/K1 are used as fixed constants.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; x is the signed sample
//   k_load,k0_in,k1_in  constant reload (reload build only)
//   out_valid/out_ready output handshake; y0/y1 are signed products (W+CW bits)

module mcm_dual_pipe #(
    parameter int W   = 8,
    parameter int CW  = 13,
    parameter int K0  = 5748,
    parameter int K1  = 87,
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      x,
    input  logic              k_load,
    input  logic [CW-1:0]     k0_in,
    input  logic [CW-1:0]     k1_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W+CW-1:0]   y0,
    output logic [W+CW-1:0]   y1
);

    localparam int S = W + CW;

    logic [CW-1:0] k0_c;
    logic [CW-1:0] k1_c;

`ifdef MCM_DUAL_PIPE_RELOAD_EN
    logic [CW-1:0] k0_q, k0_d;
    logic [CW-1:0] k1_q, k1_d;

    always_comb begin
        k0_d = k0_q;
        k1_d = k1_q;
        if (k_load) begin
            k0_d = k0_in;
            k1_d = k1_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k0_q <= CW'(K0);
            k1_q <= CW'(K1);
        end else begin
            k0_q <= k0_d;
            k1_q <= k1_d;
        end
    end

    // A sample accepted in the k_load cycle sees the old register values.
    assign k0_c = k0_q;
    assign k1_c = k1_q;
`else
    logic unused_reload;
    assign unused_reload = ^{k_load, k0_in, k1_in};
    assign k0_c = CW'(K0);
    assign k1_c = CW'(K1);
`endif

    // Packed constant: k1 in the upper field, k0 in the lower field, each S bits.
    logic [2*S-1:0]      a_pack;
    logic signed [2*S:0] prod;
    logic [S-1:0]        y0_c;
    logic [S-1:0]        y1_c;
    logic                unused_prod;

    assign a_pack = {{W{1'b0}}, k1_c, {W{1'b0}}, k0_c};
    // The zero-extended A is treated as signed so x keeps its sign.
    assign prod   = $signed(x) * $signed({1'b0, a_pack});
    // Only the low 2S bits matter: y1 is taken modulo 2^S anyway.
    assign y0_c   = prod[S-1:0];
    assign y1_c   = prod[2*S-1:S] + S'(prod[S-1]);
    assign unused_prod = prod[2*S];

    logic [LAT-1:0] vld_q, vld_d;
    logic [S-1:0]   y0_q [LAT];
    logic [S-1:0]   y0_d [LAT];
    logic [S-1:0]   y1_q [LAT];
    logic [S-1:0]   y1_d [LAT];
    logic [LAT-1:0] free;

    // Stage i can take data unless it and every later stage are full and the
    // output is stalled. This is computed without a chain so each bit is independent.
    always_comb begin
        free = '0;
        for (int i = 0; i < LAT; i++) begin
            logic full;
            full = 1'b1;
            for (int j = i; j < LAT; j++) begin
                full = full & vld_q[j];
            end
            free[i] = out_ready | ~full;
        end
    end

    always_comb begin
        vld_d = vld_q;
        y0_d  = y0_q;
        y1_d  = y1_q;
        if (free[0]) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                y0_d[0] = y0_c;
                y1_d[0] = y1_c;
            end
        end
        for (int i = 1; i < LAT; i++) begin
            if (free[i]) begin
                vld_d[i] = vld_q[i-1];
                // Data only moves with a valid, so the output holds its last value.
                if (vld_q[i-1]) begin
                    y0_d[i] = y0_q[i-1];
                    y1_d[i] = y1_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                y0_q[i] <= '0;
                y1_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < LAT; i++) begin
                y0_q[i] <= y0_d[i];
                y1_q[i] <= y1_d[i];
            end
        end
    end

    assign in_ready  = free[0];
    assign out_valid = vld_q[LAT-1];
    assign y0        = y0_q[LAT-1];
    assign y1        = y1_q[LAT-1];

endmodule

// File: tb/tb_mcm_dual_pipe.sv
// Testbench for mcm_dual_pipe. Stimulus pushes expected products into a
// scoreboard queue. A monitor pops and compares on every output handshake.
// It also checks output hold under stall and the latency where one is fixed.

module tb_mcm_dual_pipe;

    localparam int W   = 8;
    localparam int CW  = 13;
    localparam int K0  = 5748;
    localparam int K1  = 87;
    localparam int LAT = 2;
    localparam int S   = W + CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x;
    logic          k_load;
    logic [CW-1:0] k0_in;
    logic [CW-1:0] k1_in;
    logic          out_valid;
    logic          out_ready;
    logic [S-1:0]  y0;
    logic [S-1:0]  y1;

    mcm_dual_pipe #(
        .W  (W),
        .CW (CW),
        .K0 (K0),
        .K1 (K1),
        .LAT(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .k_load   (k_load),
        .k0_in    (k0_in),
        .k1_in    (k1_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y0       (y0),
        .y1       (y1)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint e0;
        longint e1;
        int     cyc;
        bit     lat;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    longint mk0   = K0;
    longint mk1   = K1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint mulk(input longint xv, input longint k);
        return xv * k;
    endfunction

    task automatic sb_push(input longint e0, input longint e1, input bit lat);
        exp_t e;
        e.e0  = e0;
        e.e1  = e1;
        e.cyc = cyc;
        e.lat = lat;
        sb.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares outputs against the scoreboard and checks hold under stall.
    initial begin
        bit     prev_stall;
        longint p0;
        longint p1;
        exp_t   e;
        prev_stall = 1'b0;
        p0 = 0;
        p1 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", longint'(out_valid), 1);
                    chk("hold_y0", longint'($signed(y0)), p0);
                    chk("hold_y1", longint'($signed(y1)), p1);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("stale_output_queue_size", longint'(sb.size()), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("y0", longint'($signed(y0)), e.e0);
                        chk("y1", longint'($signed(y1)), e.e1);
                        if (e.lat) chk("latency", longint'(cyc - e.cyc), LAT);
                    end
                end
                prev_stall = out_valid && !out_ready;
                p0 = longint'($signed(y0));
                p1 = longint'($signed(y1));
            end
        end
    end

    // One cycle of stimulus. It also checks in_ready against the occupancy the
    // scoreboard implies.
    task automatic drive_cycle(input logic v, input logic [W-1:0] xv, input logic ld,
                               input logic [CW-1:0] a, input logic [CW-1:0] b,
                               input logic ordy, output bit acc);
        logic exp_rdy;
        @(posedge clk);
        #1;
        in_valid  = v;
        x         = xv;
        k_load    = ld;
        k0_in     = a;
        k1_in     = b;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = ordy || (sb.size() < LAT);
        chk("in_ready", longint'(in_ready), longint'(exp_rdy));
        acc = v && in_ready;
    endtask

    // Offer one sample until it is accepted, then record its expected result.
    task automatic offer(input int xv, input logic ld, input logic [CW-1:0] a,
                         input logic [CW-1:0] b, input longint e0, input longint e1,
                         input bit lat);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            drive_cycle(1'b1, W'(xv), ld, a, b, 1'b1, acc);
        end
        if (acc) sb_push(e0, e1, lat);
        else chk("accept_timeout", 0, 1);
    endtask

    task automatic idle_cycle(input logic ordy);
        bit acc;
        drive_cycle(1'b0, '0, 1'b0, '0, '0, ordy, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) idle_cycle(1'b1);
        chk("drain_empty", longint'(sb.size()), 0);
    endtask

    initial begin
        bit acc;
        int idx;
        int guard;
        int cur;

        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        k_load    = 1'b0;
        k0_in     = '0;
        k1_in     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_y0", longint'(y0), 0);
        chk("reset_y1", longint'(y1), 0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", longint'(in_ready), 1);

        // Corner samples with hand-computed products.
        offer(127, 1'b0, '0, '0, 729996, 11049, 1'b1);
        offer(-128, 1'b0, '0, '0, -735744, -11136, 1'b1);
        offer(-1, 1'b0, '0, '0, -5748, -87, 1'b1);
        offer(0, 1'b0, '0, '0, 0, 0, 1'b1);
        drain();

        // Full sweep at one sample per cycle. The latency check rules out bubbles.
        for (int v = -128; v < 128; v++) begin
            offer(v, 1'b0, '0, '0, mulk(v, mk0), mulk(v, mk1), 1'b1);
        end
        drain();

        // Random back-pressure.
        idx   = 0;
        guard = 0;
        cur   = int'($urandom_range(0, 255)) - 128;
        while (idx < 1000 && guard < 20000) begin
            drive_cycle(1'($urandom_range(0, 1)), W'(cur), 1'b0, '0, '0,
                        1'($urandom_range(0, 1)), acc);
            if (acc) begin
                sb_push(mulk(cur, mk0), mulk(cur, mk1), 1'b0);
                idx++;
                cur = int'($urandom_range(0, 255)) - 128;
            end
            guard++;
        end
        chk("bp_samples_accepted", longint'(idx), 1000);
        drain();

        // Reload while streaming x=3.
        offer(3, 1'b0, '0, '0, 17244, 261, 1'b1);
        offer(3, 1'b1, 13'd8191, 13'd0, 17244, 261, 1'b1);
`ifdef MCM_DUAL_PIPE_RELOAD_EN
        mk0 = 8191;
        mk1 = 0;
        offer(3, 1'b0, '0, '0, 24573, 0, 1'b1);
`else
        offer(3, 1'b0, '0, '0, 17244, 261, 1'b1);
`endif
        offer(-7, 1'b0, '0, '0, mulk(-7, mk0), mulk(-7, mk1), 1'b1);
        drain();

        // Reset with two samples held in the pipe.
        drive_cycle(1'b1, W'(11), 1'b0, '0, '0, 1'b0, acc);
        if (acc) sb_push(mulk(11, mk0), mulk(11, mk1), 1'b0);
        drive_cycle(1'b1, W'(12), 1'b0, '0, '0, 1'b0, acc);
        if (acc) sb_push(mulk(12, mk0), mulk(12, mk1), 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("inflight_valid", longint'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_y0", longint'(y0), 0);
        chk("midrst_y1", longint'(y1), 0);
        sb.delete();
        mk0 = K0;
        mk1 = K1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", longint'(in_ready), 1);
        offer(5, 1'b0, '0, '0, 28740, 435, 1'b1);
        drain();
        repeat (4) idle_cycle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
